// File: rtl/led_scroll_ctrl_if.sv
// Host-side bundle for the scrolling LED controller: message writes,
// start/stop requests and the multiplexed digit outputs.
interface led_scroll_ctrl_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic       start;
    logic       stop;
    logic [3:0] an;
    logic [2:0] char;
    logic       busy;
    logic       scroll_wrap;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop,
        input  an, char, busy, scroll_wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop,
        output an, char, busy, scroll_wrap
    );
endinterface

// File: rtl/led_scroll_ctrl.sv
// Four-digit multiplexed display that scrolls a 16-entry message store.
// IDLE/RUN/HOLD control; an/char are registered and load together on each digit step.
module led_scroll_ctrl #(
    parameter int REFRESH_CNT = 50000,
    parameter int SCROLL_CNT  = 25000000,
    parameter int MSG_LEN     = 16
) (
    input  logic             clk,
    input  logic             reset,
    led_scroll_ctrl_if.slave bus
);

    localparam int RW = $clog2(REFRESH_CNT);
    localparam int SW = $clog2(SCROLL_CNT);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rcnt;
    logic [SW-1:0] scnt;
    logic [1:0]    dig;
    logic [3:0]    off;
    logic [2:0]    msg [16];
    logic [3:0]    an_q;
    logic [2:0]    char_q;
    logic          wrap_q;

    logic          busy, enter_run, scanning, scrolling;
    logic          r_wrap, s_wrap;
    logic [3:0]    off_nxt;
    logic [1:0]    dig_nxt;
    logic [4:0]    sum;
    logic [3:0]    idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // stop always wins over start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.stop) state_nxt = RUN;
            RUN:     if (bus.stop) state_nxt = HOLD;
            HOLD:    if (bus.stop) state_nxt = IDLE;
                     else if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        enter_run = 1'b0;
        scanning  = 1'b0;
        scrolling = 1'b0;
        case (state)
            IDLE: enter_run = (state_nxt == RUN);
            RUN: begin
                busy      = 1'b1;
                scanning  = 1'b1;
                scrolling = 1'b1;
            end
            HOLD: begin
                busy     = 1'b1;
                scanning = (state_nxt != IDLE);
            end
            default: ;
        endcase
    end

    // Next-edge offset/digit feed the char lookup so shifts show on the same update
    always_comb begin
        r_wrap  = (rcnt == RW'(REFRESH_CNT - 1));
        s_wrap  = scrolling && (scnt == SW'(SCROLL_CNT - 1));
        off_nxt = off;
        if (s_wrap) off_nxt = (off == 4'(MSG_LEN - 1)) ? 4'd0 : off + 4'd1;
        dig_nxt = dig - 2'd1;
        sum     = {1'b0, off_nxt} + 5'd3 - {3'b000, dig_nxt};
        if (sum >= 5'(MSG_LEN)) idx = 4'(sum - 5'(MSG_LEN));
        else                    idx = sum[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt   <= '0;
            scnt   <= '0;
            dig    <= 2'd0;
            off    <= 4'd0;
            an_q   <= 4'b1111;
            char_q <= 3'b000;
            wrap_q <= 1'b0;
            for (int i = 0; i < 16; i++) msg[i] <= 3'b000;
        end else begin
            if (bus.wr_en && ({1'b0, bus.wr_addr} < 5'(MSG_LEN)))
                msg[bus.wr_addr] <= bus.wr_data;
            wrap_q <= s_wrap && (off == 4'(MSG_LEN - 1));
            if (enter_run) begin
                rcnt   <= '0;
                scnt   <= '0;
                dig    <= 2'd3;
                off    <= 4'd0;
                an_q   <= 4'b0111;
                char_q <= msg[off];
            end else if (scanning) begin
                rcnt <= r_wrap ? '0 : rcnt + 1'b1;
                if (scrolling) begin
                    scnt <= s_wrap ? '0 : scnt + 1'b1;
                    off  <= off_nxt;
                end
                if (r_wrap) begin
                    dig    <= dig_nxt;
                    an_q   <= ~(4'b0001 << dig_nxt);
                    char_q <= msg[idx];
                end
            end else begin
                rcnt   <= '0;
                scnt   <= '0;
                dig    <= 2'd0;
                off    <= 4'd0;
                an_q   <= 4'b1111;
                char_q <= 3'b000;
            end
        end
    end

    assign bus.an          = an_q;
    assign bus.char        = char_q;
    assign bus.busy        = busy;
    assign bus.scroll_wrap = wrap_q;

endmodule

// File: doc/led_scroll_ctrl.md
LED_SCROLL_CTRL -- requirements
Module: led_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_CNT, default 50000, giving the clock cycles each digit stays enabled (legal range 2..2^20).
REQ-002 The block SHALL have parameter SCROLL_CNT, default 25000000, giving the clock cycles between message shifts (legal range 2..2^26).
REQ-003 The block SHALL have parameter MSG_LEN, default 16, giving the number of active message entries (legal range 4..16).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  message write strobe.
REQ-007 wr_addr  input  4  message entry index.
REQ-008 wr_data  input  3  character code, in the 3-bit code set accepted by the 7-segment decoder.
REQ-009 start  input  1  single-cycle request to begin or resume scrolling.
REQ-010 stop  input  1  single-cycle request to freeze the scroll, or to blank the display.
REQ-011 an  output  4  digit enables, active-low; an[3] is the leftmost digit.
REQ-012 char  output  3  code of the currently enabled digit, to the decoder char input.
REQ-013 busy  output  1  high in RUN or HOLD.
REQ-014 scroll_wrap  output  1  one-cycle pulse when the scroll offset wraps from MSG_LEN-1 to 0.

Function
REQ-015 The block SHALL hold a 16x3 message store; when wr_en=1 and wr_addr<MSG_LEN, entry wr_addr SHALL take wr_data at the clock edge; writes with wr_addr>=MSG_LEN SHALL be ignored.
REQ-016 Writes SHALL be accepted in every state; a read in the same cycle as a write to the same entry SHALL return the old value.
REQ-017 The FSM SHALL have states IDLE, RUN and HOLD.
REQ-018 IDLE behaviour: an=4'b1111, char=3'b000, and the refresh counter, scroll counter, digit index and offset are held at 0.
REQ-019 IDLE transitions: start=1 with stop=0 SHALL go to RUN.
REQ-020 RUN transitions: stop=1 SHALL go to HOLD; start SHALL be ignored.
REQ-021 HOLD transitions: start=1 with stop=0 SHALL go to RUN; stop=1 SHALL go to IDLE and clear the offset.
REQ-022 When start and stop are high in the same cycle, stop SHALL take priority.
REQ-023 Digit scan in RUN and HOLD: the refresh counter SHALL count 0..REFRESH_CNT-1 and wrap. At each wrap the digit index SHALL step 3->2->1->0->3.
REQ-024 For digit index d, an SHALL be all ones except an[d]=0.
REQ-025 For digit index d, char SHALL equal msg[(offset+3-d) mod MSG_LEN].
REQ-026 an and char SHALL be registered and SHALL change on the same edge.
REQ-027 On the edge that moves IDLE->RUN, an SHALL become 4'b0111 and char SHALL become msg[offset].
REQ-028 Scroll in RUN only: the scroll counter SHALL count 0..SCROLL_CNT-1 and wrap; at each wrap the offset SHALL increment modulo MSG_LEN.
REQ-029 When the offset wraps from MSG_LEN-1 to 0, scroll_wrap SHALL be 1 for exactly that cycle.
REQ-030 Offset changes SHALL take effect on the next char update, with no extra latency.
REQ-031 In HOLD the scroll counter and offset SHALL be frozen at their current values, and the digit scan SHALL continue.
REQ-032 On HOLD->RUN the scroll counter SHALL resume from its frozen value.
REQ-033 On any transition into IDLE, an, char and all counters SHALL take their IDLE values on that same edge.
REQ-034 A write to an entry that is currently displayed SHALL appear on char at the next char update.

Reset
REQ-035 While reset=1 the block SHALL immediately force state=IDLE, an=4'b1111, char=3'b000, busy=0, scroll_wrap=0, all counters and the offset to 0, and all message entries to 3'b000, independent of clk.
REQ-036 Reset asserted mid-scan or mid-write SHALL discard all in-progress activity, and no write SHALL complete in the cycle reset deasserts.
REQ-037 The first start after reset release SHALL behave exactly as REQ-027.

Verification (REFRESH_CNT=4, SCROLL_CNT=32, MSG_LEN=16)
REQ-038 Write msg[0..3]=0,1,2,3, pulse start -> an: 0111,1011,1101,1110, each held 4 cycles, with char 0,1,2,3; busy=1.
REQ-039 Continue running -> after 32 cycles the offset is 1 and digit 3 shows msg[1]=1; after 16x32=512 cycles scroll_wrap pulses once and the offset is 0.
REQ-040 Pulse stop in RUN -> the offset stays constant for 200 cycles while an keeps rotating; then pulse start -> the scroll resumes and the next shift occurs at the remaining count.
REQ-041 Pulse start and stop in the same cycle while in IDLE -> the state stays IDLE and an=1111; same pulse while in HOLD -> IDLE with offset 0.
REQ-042 Assert reset mid-scan while asynchronous to clk -> an=1111 and busy=0 without waiting for an edge; after release, all entries read 0.
REQ-043 Write wr_addr=5 with MSG_LEN=4 -> no entry changes; write to the displayed entry -> char updates at the next char update.
